mul_acc_stage: RTL and testbench
================================

# mul_acc_stage

Downstream consumer of the array multiplier's 2*WIDTH-bit product. It accumulates a programmed number of consecutive products into a wide accumulator (dot-product reduction for the vector unit). It then presents the sum on a valid/ready output. Products arrive on a valid/ready input, so the block absorbs multiplier-side bubbles and result-side backpressure.

## Interface
- WIDTH, 16, multiplier operand width; product width PROD_WIDTH = 2*WIDTH (localparam)
- ACC_WIDTH, 40, accumulator width; must be >= PROD_WIDTH
- CNT_WIDTH, 8, width of the element-count field
- clk  input  1  single clock; all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a reduction; honoured only in IDLE
- len  input  CNT_WIDTH  number of products to accumulate; sampled with start
- is_signed  input  1  1: products are two's complement, 0: unsigned; sampled with start
- prod_valid  input  1  product available
- prod_ready  output  1  block accepts a product this cycle
- prod_data  input  PROD_WIDTH  product from the multiplier
- acc_valid  output  1  result available
- acc_ready  input  1  consumer takes the result
- acc_data  output  ACC_WIDTH  accumulated sum
- acc_overflow  output  1  sticky: the sum exceeded the ACC_WIDTH range during this reduction
- busy  output  1  high in ACCUM and DONE

## Operation
- FSM states are IDLE, ACCUM and DONE.
- IDLE:
  - prod_ready=0, acc_valid=0, busy=0.
  - On start: latch len and is_signed into remaining and sgn, clear acc and acc_overflow.
  - Go to DONE if len==0, else go to ACCUM.
- ACCUM:
  - prod_ready=1.
  - On each prod_valid&&prod_ready: acc <= acc + ext(prod_data), where ext is a sign-extension when sgn=1 and a zero-extension otherwise; remaining decrements.
  - The handshake that takes remaining from 1 to 0 moves the FSM to DONE.
- DONE:
  - acc_valid=1, and acc_data/acc_overflow are held stable.
  - prod_ready=0.
  - On acc_ready, go to IDLE.
- start is ignored outside IDLE, and len/is_signed are not re-sampled.
- Overflow is evaluated per addition in the latched signedness:
  - unsigned: carry out of ACC_WIDTH;
  - signed: both operands have the same sign and the result sign differs.
  - Overflow sets acc_overflow, which stays set until the next start.
- acc_data is driven directly from the accumulator register and reads 0 in IDLE after reset.

## Timing
- Reset (async assert, sync deassert): state=IDLE, acc=0, remaining=0, and every output is 0 (prod_ready, acc_valid, acc_data, acc_overflow, busy).
- prod_ready, acc_valid and busy are decoded from the registered state, with no combinational path from the inputs.
- With start at cycle 0, len=N>0, and prod_valid held high:
  - products are accepted in cycles 1..N;
  - acc_valid is high from cycle N+1.
- With len=0, acc_valid is high in cycle 1.
- Bubbles (prod_valid=0) stall accumulation without changing any state.
- The earliest next start is accepted the cycle after the acc_valid&&acc_ready handshake.
- Reset asserted in any state aborts the reduction immediately. Products in flight are discarded; the upstream does not replay them.

## Configuration
- MUL_ACC_SATURATE_EN, when defined:
  - An overflowing addition clamps acc to the range limit: unsigned 2^ACC_WIDTH-1; signed max positive or min negative according to the direction.
  - Once clamped, acc keeps accumulating from the clamp value.
- When not defined, additions wrap modulo 2^ACC_WIDTH.
- acc_overflow behaves identically in both builds.

## Test plan
- Unsigned, len=3, products 6, 7, 100 back-to-back after start at cycle 0 -> acc_valid at cycle 4, acc_data=113, acc_overflow=0.
- Signed, len=2, products 0xFFFFFFFE and 5 -> acc_data=3. The same stimulus unsigned -> acc_data=0x1_00000003.
- len=4 with prod_valid gaps of 2 cycles and acc_ready low for 5 cycles in DONE -> sum correct, acc_data stable, prod_ready=0 throughout DONE, and a start during DONE is ignored.
- len=0 -> acc_valid in cycle 1, acc_data=0, no product consumed even while prod_valid=1.
- ACC_WIDTH=33, unsigned, len=3, three products of 0xFFFFFFFF -> acc_overflow=1; acc_data=0x1_FFFFFFFF with MUL_ACC_SATURATE_EN defined, 0x0_FFFFFFFD without it.
- rst_n pulsed low mid-ACCUM after 2 of 5 products -> all outputs 0 immediately; a new start with len=1 and product 9 -> acc_data=9.

Source files
------------

// File: rtl/mul_acc_if.sv
// Valid/ready bundle between the vector unit, the multiplier product stream
// and the mul_acc_stage reduction block.
interface mul_acc_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 8
);
    localparam int PROD_WIDTH = 2 * WIDTH;

    logic                  start;
    logic [CNT_WIDTH-1:0]  len;
    logic                  is_signed;
    logic                  prod_valid;
    logic                  prod_ready;
    logic [PROD_WIDTH-1:0] prod_data;
    logic                  acc_valid;
    logic                  acc_ready;
    logic [ACC_WIDTH-1:0]  acc_data;
    logic                  acc_overflow;
    logic                  busy;

    modport master (
        output start, len, is_signed, prod_valid, prod_data, acc_ready,
        input  prod_ready, acc_valid, acc_data, acc_overflow, busy
    );

    modport slave (
        input  start, len, is_signed, prod_valid, prod_data, acc_ready,
        output prod_ready, acc_valid, acc_data, acc_overflow, busy
    );
endinterface

// File: rtl/mul_acc_stage.sv
// Accumulates a programmed number of multiplier products and presents the sum
// on a valid/ready output. Define MUL_ACC_SATURATE_EN to clamp on overflow.
module mul_acc_stage #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 8
) (
    input logic     clk,
    input logic     rst_n,
    mul_acc_if.slave bus
);
    localparam int PROD_WIDTH = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic                   sgn_q, sgn_d;
    logic                   ovf_q, ovf_d;
    logic                   prod_ready_q, prod_ready_d;
    logic                   acc_valid_q, acc_valid_d;
    logic                   busy_q, busy_d;

    logic signed [PROD_WIDTH-1:0] prod_s;
    logic [ACC_WIDTH-1:0]   ext;
    logic [ACC_WIDTH:0]     sum;
    logic                   add_ovf;
    logic [ACC_WIDTH-1:0]   add_res;
`ifdef MUL_ACC_SATURATE_EN
    logic [ACC_WIDTH-1:0]   sat_val;
`endif

    // Operand extension and a single ACC_WIDTH+1 adder shared by both signedness modes.
    always_comb begin
        prod_s = bus.prod_data;
        if (sgn_q) begin
            ext = ACC_WIDTH'(prod_s);
        end else begin
            ext = ACC_WIDTH'(bus.prod_data);
        end
        sum = {1'b0, acc_q} + {1'b0, ext};
        if (sgn_q) begin
            add_ovf = (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum[ACC_WIDTH];
        end
`ifdef MUL_ACC_SATURATE_EN
        if (!sgn_q) begin
            sat_val = '1;
        end else if (acc_q[ACC_WIDTH-1]) begin
            sat_val = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        add_res = add_ovf ? sat_val : sum[ACC_WIDTH-1:0];
`else
        add_res = sum[ACC_WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        sgn_d       = sgn_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.len;
                    sgn_d       = bus.is_signed;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = (bus.len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                // prod_ready is high throughout ACCUM, so prod_valid alone is the handshake.
                if (bus.prod_valid) begin
                    acc_d       = add_res;
                    ovf_d       = ovf_q | add_ovf;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track state_q exactly.
    always_comb begin
        prod_ready_d = (state_d == ACCUM);
        acc_valid_d  = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            remaining_q  <= '0;
            sgn_q        <= 1'b0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            remaining_q  <= remaining_d;
            sgn_q        <= sgn_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= prod_ready_d;
            acc_valid_q  <= acc_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.prod_ready   = prod_ready_q;
    assign bus.acc_valid    = acc_valid_q;
    assign bus.busy         = busy_q;
    assign bus.acc_data     = acc_q;
    assign bus.acc_overflow = ovf_q;

endmodule

// File: tb/tb_mul_acc_stage.sv
// Directed bench for mul_acc_stage: a default 40-bit instance and a 33-bit
// instance for the overflow/saturation case (honours MUL_ACC_SATURATE_EN).
module tb_mul_acc_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mul_acc_if #(.WIDTH(16), .ACC_WIDTH(40), .CNT_WIDTH(8)) bus ();
    mul_acc_if #(.WIDTH(16), .ACC_WIDTH(33), .CNT_WIDTH(8)) bus33 ();

    mul_acc_stage #(.WIDTH(16), .ACC_WIDTH(40), .CNT_WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mul_acc_stage #(.WIDTH(16), .ACC_WIDTH(33), .CNT_WIDTH(8)) u_dut33 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus33.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_red(input logic [7:0] n, input logic sgn);
        bus.start     = 1'b1;
        bus.len       = n;
        bus.is_signed = sgn;
        tick();
        bus.start     = 1'b0;
    endtask

    // Present one product and return in the cycle after it was accepted.
    task automatic feed(input logic [31:0] d);
        bit done;
        done           = 1'b0;
        bus.prod_valid = 1'b1;
        bus.prod_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.prod_ready) done = 1'b1;
            tick();
        end
        if (!done) check("feed_timeout", 64'd0, 64'd1);
    endtask

    task automatic release_result();
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [63:0] exp33;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.is_signed = 1'b0;
        bus.prod_valid = 1'b0; bus.prod_data = '0; bus.acc_ready = 1'b0;
        bus33.start = 1'b0; bus33.len = '0; bus33.is_signed = 1'b0;
        bus33.prod_valid = 1'b0; bus33.prod_data = '0; bus33.acc_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_prod_ready", 64'(bus.prod_ready), 64'd0);
        check("rst_acc_valid", 64'(bus.acc_valid), 64'd0);
        check("rst_acc_data", 64'(bus.acc_data), 64'd0);
        check("rst_overflow", 64'(bus.acc_overflow), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_acc_data", 64'(bus.acc_data), 64'd0);

        // Unsigned 6+7+100, back-to-back; result at cycle 4.
        start_red(8'd3, 1'b0);
        check("t1_c1_prod_ready", 64'(bus.prod_ready), 64'd1);
        check("t1_c1_acc_valid", 64'(bus.acc_valid), 64'd0);
        check("t1_c1_busy", 64'(bus.busy), 64'd1);
        feed(32'd6);
        feed(32'd7);
        check("t1_c3_acc_valid", 64'(bus.acc_valid), 64'd0);
        feed(32'd100);
        bus.prod_valid = 1'b0;
        check("t1_c4_acc_valid", 64'(bus.acc_valid), 64'd1);
        check("t1_acc_data", 64'(bus.acc_data), 64'd113);
        check("t1_overflow", 64'(bus.acc_overflow), 64'd0);
        check("t1_done_prod_ready", 64'(bus.prod_ready), 64'd0);
        release_result();
        check("t1_idle_acc_valid", 64'(bus.acc_valid), 64'd0);
        check("t1_idle_busy", 64'(bus.busy), 64'd0);

        // Signed -2+5, started on the first cycle after the handshake.
        start_red(8'd2, 1'b1);
        check("t2s_prod_ready", 64'(bus.prod_ready), 64'd1);
        feed(32'hFFFF_FFFE);
        feed(32'd5);
        bus.prod_valid = 1'b0;
        check("t2s_acc_valid", 64'(bus.acc_valid), 64'd1);
        check("t2s_acc_data", 64'(bus.acc_data), 64'd3);
        check("t2s_overflow", 64'(bus.acc_overflow), 64'd0);
        release_result();
        start_red(8'd2, 1'b0);
        feed(32'hFFFF_FFFE);
        feed(32'd5);
        bus.prod_valid = 1'b0;
        check("t2u_acc_data", 64'(bus.acc_data), 64'h1_0000_0003);
        check("t2u_overflow", 64'(bus.acc_overflow), 64'd0);
        release_result();

        // Gapped products, then backpressure in DONE with a stray start.
        start_red(8'd4, 1'b0);
        feed(32'd10);
        bus.prod_valid = 1'b0; tick(); tick();
        check("t3_gap_acc_data", 64'(bus.acc_data), 64'd10);
        check("t3_gap_busy", 64'(bus.busy), 64'd1);
        feed(32'd20);
        bus.prod_valid = 1'b0; tick(); tick();
        feed(32'd30);
        bus.prod_valid = 1'b0; tick(); tick();
        check("t3_pre_last_acc_valid", 64'(bus.acc_valid), 64'd0);
        feed(32'd40);
        bus.prod_valid = 1'b1;
        bus.prod_data  = 32'h55;
        bus.start      = 1'b1;
        bus.len        = 8'd7;
        for (int i = 0; i < 5; i++) begin
            check("t3_done_acc_valid", 64'(bus.acc_valid), 64'd1);
            check("t3_done_prod_ready", 64'(bus.prod_ready), 64'd0);
            check("t3_done_acc_data", 64'(bus.acc_data), 64'd100);
            tick();
        end
        bus.start      = 1'b0;
        bus.prod_valid = 1'b0;
        release_result();
        check("t3_start_ignored_busy", 64'(bus.busy), 64'd0);
        check("t3_start_ignored_valid", 64'(bus.acc_valid), 64'd0);

        // len=0 completes without consuming the offered product.
        bus.prod_valid = 1'b1;
        bus.prod_data  = 32'h77;
        start_red(8'd0, 1'b0);
        check("t4_c1_acc_valid", 64'(bus.acc_valid), 64'd1);
        check("t4_c1_prod_ready", 64'(bus.prod_ready), 64'd0);
        check("t4_acc_data", 64'(bus.acc_data), 64'd0);
        tick();
        check("t4_acc_data_held", 64'(bus.acc_data), 64'd0);
        bus.prod_valid = 1'b0;
        release_result();

        // 33-bit accumulator: 3 x 0xFFFFFFFF overflows on the third add.
        bus33.start = 1'b1;
        bus33.len   = 8'd3;
        tick();
        bus33.start      = 1'b0;
        bus33.prod_valid = 1'b1;
        bus33.prod_data  = 32'hFFFF_FFFF;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            if (bus33.prod_ready) cnt++;
            tick();
        end
        bus33.prod_valid = 1'b0;
        check("t5_accepted", 64'(cnt), 64'd3);
`ifdef MUL_ACC_SATURATE_EN
        exp33 = 64'h1_FFFF_FFFF;
`else
        exp33 = 64'h0_FFFF_FFFD;
`endif
        check("t5_acc_valid", 64'(bus33.acc_valid), 64'd1);
        check("t5_overflow", 64'(bus33.acc_overflow), 64'd1);
        check("t5_acc_data", 64'(bus33.acc_data), exp33);
        bus33.acc_ready = 1'b1; tick(); bus33.acc_ready = 1'b0;
        bus33.start = 1'b1;
        bus33.len   = 8'd1;
        tick();
        bus33.start = 1'b0;
        check("t5b_overflow_cleared", 64'(bus33.acc_overflow), 64'd0);
        bus33.prod_valid = 1'b1;
        bus33.prod_data  = 32'd1;
        tick();
        bus33.prod_valid = 1'b0;
        check("t5b_acc_data", 64'(bus33.acc_data), 64'd1);
        check("t5b_acc_valid", 64'(bus33.acc_valid), 64'd1);
        bus33.acc_ready = 1'b1; tick(); bus33.acc_ready = 1'b0;

        // Asynchronous reset mid-ACCUM after 2 of 5 products.
        start_red(8'd5, 1'b0);
        feed(32'd1);
        feed(32'd2);
        bus.prod_data = 32'd3;
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_prod_ready", 64'(bus.prod_ready), 64'd0);
        check("t6_rst_acc_valid", 64'(bus.acc_valid), 64'd0);
        check("t6_rst_acc_data", 64'(bus.acc_data), 64'd0);
        check("t6_rst_overflow", 64'(bus.acc_overflow), 64'd0);
        check("t6_rst_busy", 64'(bus.busy), 64'd0);
        bus.prod_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_red(8'd1, 1'b0);
        feed(32'd9);
        bus.prod_valid = 1'b0;
        check("t6_acc_valid", 64'(bus.acc_valid), 64'd1);
        check("t6_acc_data", 64'(bus.acc_data), 64'd9);
        check("t6_overflow", 64'(bus.acc_overflow), 64'd0);
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
